// File: rtl/wshbn_interconnect.sv
// Single-master Wishbone interconnect: address decode to one-hot slave strobe, ack/data mux,
// timeout watchdog with error response. Define WB_REG_RESP_EN to register the master response path.
module wshbn_interconnect #(
    parameter int N_SLAVES = 4,
    parameter int ADR_W    = 8,
    parameter int DAT_W    = 32,
    parameter int DEC_W    = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      CYC_O_M0,
    input  logic                      STB_O_M0,
    input  logic                      WE_O_M0,
    input  logic [ADR_W-1:0]          ADR_O_M0,
    input  logic [DAT_W-1:0]          DAT_O_M0,
    output logic                      ACK_I_M0,
    output logic                      ERR_I_M0,
    output logic [DAT_W-1:0]          DAT_I_M0,
    output logic [N_SLAVES-1:0]       STB_I_S,
    output logic [ADR_W-1:0]          ADR_I_S,
    output logic [DAT_W-1:0]          DAT_I_S,
    output logic                      WE_I_S,
    input  logic [N_SLAVES-1:0]       ACK_O_S,
    input  logic [N_SLAVES*DAT_W-1:0] DAT_O_S,
    output logic [7:0]                err_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t              state;
    logic [DEC_W-1:0]    idx;
    logic [CNT_W-1:0]    cnt;
    logic                err_r;
    logic [DEC_W-1:0]    dec_idx;
    logic [N_SLAVES-1:0] dec_onehot;
    logic                mapped;
    logic                sel_ack;
    logic [DAT_W-1:0]    sel_dat;
    logic                ack_now;

    assign ADR_I_S  = ADR_O_M0;
    assign DAT_I_S  = DAT_O_M0;
    assign WE_I_S   = WE_O_M0;
    assign ERR_I_M0 = err_r;
    assign dec_idx  = ADR_O_M0[ADR_W-1 -: DEC_W];

    always_comb begin
        dec_onehot = '0;
        sel_ack    = 1'b0;
        sel_dat    = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            dec_onehot[k] = (dec_idx == DEC_W'(k));
            if (idx == DEC_W'(k)) begin
                sel_ack = ACK_O_S[k];
                sel_dat = DAT_O_S[k*DAT_W +: DAT_W];
            end
        end
    end

    assign mapped  = |dec_onehot;
    // A dropped CYC takes priority over a late slave ack so aborts never complete.
    assign ack_now = (state == BUSY) && CYC_O_M0 && sel_ack;

`ifdef WB_REG_RESP_EN
    logic             ack_r;
    logic [DAT_W-1:0] dat_r;

    assign ACK_I_M0 = ack_r;
    assign DAT_I_M0 = dat_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_r <= 1'b0;
            dat_r <= '0;
        end else begin
            ack_r <= ack_now;
            dat_r <= ack_now ? sel_dat : '0;
        end
    end
`else
    assign ACK_I_M0 = ack_now;
    assign DAT_I_M0 = ack_now ? sel_dat : '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            STB_I_S <= '0;
            err_r   <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            err_r <= 1'b0;
            case (state)
                // A registered ack still showing in IDLE belongs to the previous transfer.
                IDLE: begin
                    if (CYC_O_M0 && STB_O_M0 && !ACK_I_M0) begin
                        if (mapped) begin
                            idx     <= dec_idx;
                            STB_I_S <= dec_onehot;
                            cnt     <= '0;
                            state   <= BUSY;
                        end else begin
                            err_r <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                BUSY: begin
                    if (!CYC_O_M0) begin
                        STB_I_S <= '0;
                        state   <= IDLE;
                    end else if (sel_ack) begin
                        STB_I_S <= '0;
                        state   <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        STB_I_S <= '0;
                        err_r   <= 1'b1;
                        state   <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wshbn_interconnect.sv
// Directed self-checking bench for wshbn_interconnect with a small scripted slave that acks
// after a programmable number of wait cycles.
module tb_wshbn_interconnect;

`ifdef WB_REG_RESP_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic         clk;
    logic         rst;
    logic         cyc_o;
    logic         stb_o;
    logic         we_o;
    logic [7:0]   adr_o;
    logic [31:0]  dat_o;
    logic         ACK_I_M0;
    logic         ERR_I_M0;
    logic [31:0]  DAT_I_M0;
    logic [3:0]   STB_I_S;
    logic [7:0]   ADR_I_S;
    logic [31:0]  DAT_I_S;
    logic         WE_I_S;
    logic [3:0]   ack_os;
    logic [127:0] dat_os;
    logic [7:0]   err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wshbn_interconnect dut (
        .clk      (clk),
        .rst      (rst),
        .CYC_O_M0 (cyc_o),
        .STB_O_M0 (stb_o),
        .WE_O_M0  (we_o),
        .ADR_O_M0 (adr_o),
        .DAT_O_M0 (dat_o),
        .ACK_I_M0 (ACK_I_M0),
        .ERR_I_M0 (ERR_I_M0),
        .DAT_I_M0 (DAT_I_M0),
        .STB_I_S  (STB_I_S),
        .ADR_I_S  (ADR_I_S),
        .DAT_I_S  (DAT_I_S),
        .WE_I_S   (WE_I_S),
        .ACK_O_S  (ack_os),
        .DAT_O_S  (dat_os),
        .err_cnt  (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one master transfer; the scripted slave acks after 'waits' strobed cycles (never if <0).
    task automatic do_transfer(input logic [7:0] adr, input logic we, input logic [31:0] wdat,
                               input int waits, input logic [31:0] rdat,
                               output int stb_cycles, output int acks, output int errs,
                               output logic [31:0] rd, output int lat, output int bad,
                               output logic [7:0] bc_adr, output logic [31:0] bc_dat,
                               output logic bc_we);
        int         sidx;
        int         seen;
        bit         done;
        logic [3:0] exp_oh;
        sidx       = int'(adr[7:4]);
        exp_oh     = (sidx < 4) ? 4'(1 << sidx) : 4'b0000;
        stb_cycles = 0;
        acks       = 0;
        errs       = 0;
        rd         = '0;
        lat        = -1;
        bad        = 0;
        bc_adr     = '0;
        bc_dat     = '0;
        bc_we      = 1'b0;
        dat_os     = '0;
        if (sidx < 4) dat_os[sidx*32 +: 32] = rdat;
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = we;
        adr_o = adr;
        dat_o = wdat;
        seen  = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            ack_os = (waits >= 0 && (STB_I_S & exp_oh) != 0 && seen == waits) ? exp_oh : 4'b0000;
            @(negedge clk);
            if (STB_I_S != 0) begin
                stb_cycles++;
                if (STB_I_S != exp_oh) bad++;
                if (stb_cycles == 1) begin
                    bc_adr = ADR_I_S;
                    bc_dat = DAT_I_S;
                    bc_we  = WE_I_S;
                end
            end
            if (ACK_I_M0) begin
                acks++;
                rd  = DAT_I_M0;
                lat = c;
            end
            if (ERR_I_M0) errs++;
            if (ACK_I_M0 && ERR_I_M0) bad++;
            if (ACK_I_M0 || ERR_I_M0) done = 1'b1;
            if ((STB_I_S & exp_oh) != 0) seen++;
            step();
            if (done) begin
                cyc_o = 1'b0;
                stb_o = 1'b0;
            end
        end
        ack_os = 4'b0000;
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (STB_I_S != 0) stb_cycles++;
            if (ACK_I_M0) acks++;
            if (ERR_I_M0) errs++;
            step();
        end
    endtask

    initial begin
        int          stb_n, ack_n, err_n, lat, bad;
        logic [31:0] rd;
        logic [7:0]  bc_adr;
        logic [31:0] bc_dat;
        logic        bc_we;

        rst    = 1'b0;
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        we_o   = 1'b0;
        adr_o  = '0;
        dat_o  = '0;
        ack_os = '0;
        dat_os = '0;
        repeat (2) step();
        @(negedge clk);
        check_output("rst_ack", 32'(ACK_I_M0), 32'd0);
        check_output("rst_err", 32'(ERR_I_M0), 32'd0);
        check_output("rst_stb", 32'(STB_I_S), 32'd0);
        check_output("rst_dat", DAT_I_M0, 32'd0);
        check_output("rst_errcnt", 32'(err_cnt), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Read slave 1, zero wait states
        do_transfer(8'h14, 1'b0, 32'h0, 0, 32'hCAFE_0001, stb_n, ack_n, err_n, rd, lat, bad, bc_adr, bc_dat, bc_we);
        check_output("t1_stb_cycles", 32'(stb_n), 32'd1);
        check_output("t1_acks", 32'(ack_n), 32'd1);
        check_output("t1_errs", 32'(err_n), 32'd0);
        check_output("t1_data", rd, 32'hCAFE_0001);
        check_output("t1_latency", 32'(lat), 32'(1 + RL));
        check_output("t1_bad", 32'(bad), 32'd0);
        check_output("t1_errcnt", 32'(err_cnt), 32'd0);

        // Write slave 2 with three wait states
        do_transfer(8'h27, 1'b1, 32'h55, 3, 32'h0, stb_n, ack_n, err_n, rd, lat, bad, bc_adr, bc_dat, bc_we);
        check_output("t2_stb_cycles", 32'(stb_n), 32'd4);
        check_output("t2_acks", 32'(ack_n), 32'd1);
        check_output("t2_latency", 32'(lat), 32'(4 + RL));
        check_output("t2_adr", 32'(bc_adr), 32'h27);
        check_output("t2_dat", bc_dat, 32'h55);
        check_output("t2_we", 32'(bc_we), 32'd1);
        check_output("t2_bad", 32'(bad), 32'd0);

        // Unmapped slave index 5
        do_transfer(8'h50, 1'b0, 32'h0, 0, 32'h0, stb_n, ack_n, err_n, rd, lat, bad, bc_adr, bc_dat, bc_we);
        check_output("t3_stb_cycles", 32'(stb_n), 32'd0);
        check_output("t3_acks", 32'(ack_n), 32'd0);
        check_output("t3_errs", 32'(err_n), 32'd1);
        check_output("t3_errcnt", 32'(err_cnt), 32'd1);

        // Slave 0 never acks: timeout after 16 strobed cycles
        do_transfer(8'h03, 1'b0, 32'h0, -1, 32'h0, stb_n, ack_n, err_n, rd, lat, bad, bc_adr, bc_dat, bc_we);
        check_output("t4_stb_cycles", 32'(stb_n), 32'd16);
        check_output("t4_acks", 32'(ack_n), 32'd0);
        check_output("t4_errs", 32'(err_n), 32'd1);
        check_output("t4_errcnt", 32'(err_cnt), 32'd2);

        // Ack on the last allowed cycle wins over the timeout
        do_transfer(8'h03, 1'b0, 32'h0, 15, 32'h0BAD_F00D, stb_n, ack_n, err_n, rd, lat, bad, bc_adr, bc_dat, bc_we);
        check_output("t4b_stb_cycles", 32'(stb_n), 32'd16);
        check_output("t4b_acks", 32'(ack_n), 32'd1);
        check_output("t4b_errs", 32'(err_n), 32'd0);
        check_output("t4b_data", rd, 32'h0BAD_F00D);
        check_output("t4b_errcnt", 32'(err_cnt), 32'd2);

        // Spurious ack from slave 3 while slave 1 is selected
        dat_os = '0;
        dat_os[32 +: 32] = 32'h1111_2222;
        dat_os[96 +: 32] = 32'hDEAD_BEEF;
        cyc_o = 1'b1;
        stb_o = 1'b1;
        we_o  = 1'b0;
        adr_o = 8'h10;
        step();
        ack_os = 4'b1000;
        @(negedge clk);
        check_output("t5_spur_ack", 32'(ACK_I_M0), 32'd0);
        check_output("t5_spur_stb", 32'(STB_I_S), 32'b0010);
        step();
        check_output("t5_spur_stb_held", 32'(STB_I_S), 32'b0010);
        ack_os = 4'b0010;
        if (RL != 0) begin
            step();
            ack_os = 4'b0000;
        end
        @(negedge clk);
        check_output("t5_real_ack", 32'(ACK_I_M0), 32'd1);
        check_output("t5_real_dat", DAT_I_M0, 32'h1111_2222);
        step();
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        ack_os = 4'b0000;
        @(negedge clk);
        check_output("t5_after_ack", 32'(ACK_I_M0), 32'd0);
        check_output("t5_after_dat", DAT_I_M0, 32'd0);
        check_output("t5_after_stb", 32'(STB_I_S), 32'd0);

        // CYC dropped mid-transfer
        step();
        cyc_o = 1'b1;
        stb_o = 1'b1;
        adr_o = 8'h20;
        repeat (3) step();
        cyc_o = 1'b0;
        stb_o = 1'b0;
        @(negedge clk);
        check_output("t5_abort_stb_pre", 32'(STB_I_S), 32'b0100);
        step();
        @(negedge clk);
        check_output("t5_abort_stb", 32'(STB_I_S), 32'd0);
        check_output("t5_abort_ack", 32'(ACK_I_M0), 32'd0);
        check_output("t5_abort_err", 32'(ERR_I_M0), 32'd0);
        repeat (20) step();
        check_output("t5_abort_errcnt", 32'(err_cnt), 32'd2);

        // Back-to-back unmapped errors saturate the error counter
        cyc_o = 1'b1;
        stb_o = 1'b1;
        adr_o = 8'hF0;
        repeat (520) step();
        cyc_o = 1'b0;
        stb_o = 1'b0;
        repeat (3) step();
        check_output("sat_errcnt", 32'(err_cnt), 32'd255);

        // Reset in the middle of a transfer
        cyc_o = 1'b1;
        stb_o = 1'b1;
        adr_o = 8'h30;
        repeat (3) step();
        @(negedge clk);
        check_output("t5_rst_stb_pre", 32'(STB_I_S), 32'b1000);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check_output("t5_rst_stb", 32'(STB_I_S), 32'd0);
        check_output("t5_rst_ack", 32'(ACK_I_M0), 32'd0);
        check_output("t5_rst_err", 32'(ERR_I_M0), 32'd0);
        check_output("t5_rst_errcnt", 32'(err_cnt), 32'd0);
        cyc_o = 1'b0;
        stb_o = 1'b0;
        step();
        rst = 1'b1;
        repeat (2) step();

        // Clean transfer after reset
        do_transfer(8'h3C, 1'b0, 32'h0, 1, 32'h1234_5678, stb_n, ack_n, err_n, rd, lat, bad, bc_adr, bc_dat, bc_we);
        check_output("t7_acks", 32'(ack_n), 32'd1);
        check_output("t7_data", rd, 32'h1234_5678);
        check_output("t7_latency", 32'(lat), 32'(2 + RL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
